neuron_mac_seq: RTL
===================

# neuron_mac_seq

Time-multiplexed, parametrised neuron. A single signed multiplier-accumulator consumes one (input, weight) pair per accepted beat over a valid/ready stream. After `INPUTS` beats it adds the bias, rescales, applies an optional ReLU, saturates to `RES` bits and emits one registered result with a one-cycle valid pulse. It replaces the fully parallel neuron wherever a layer's input count makes one multiplier per input too costly. It sits between the weight/activation memory sequencer and the layer output buffer.

## Interface
- `INPUTS`, 16: number of products accumulated per result; at least 1.
- `RES`, 8: width of data, weight, bias and output (signed two's complement).
- `BIAS_SHIFT`, 0: left shift applied to the sign-extended bias before it is added, so it aligns with the product scale.
- `OUT_SHIFT`, 0: arithmetic right shift applied to the biased sum before saturation.
- `ACT`, 0: activation; 0 = linear, 1 = ReLU.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  begin a new result; sampled only in IDLE.
- `bias`  in  RES  signed bias; latched on the accepted `start`.
- `in_valid`  in  1  the pair on `in_data`/`in_weight` is valid.
- `in_ready`  out  1  the block accepts a pair this cycle.
- `in_data`  in  RES  signed activation.
- `in_weight`  in  RES  signed weight.
- `out_valid`  out  1  one-cycle pulse; `out_data` holds a new result.
- `out_data`  out  RES  signed, saturated result; held until the next result.
- `out_sat`  out  1  clamping occurred for the current `out_data`.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states are IDLE, ACC and FIN. The reset state is IDLE.
- IDLE:
  - On `start`, latch `bias`, clear the accumulator and the beat counter, then go to ACC.
  - `start` is ignored in every other state.
- ACC:
  - `in_ready` = 1. A beat is accepted when `in_valid` and `in_ready` are both high.
  - On each accepted beat: acc += in_data × in_weight (full signed product, 2·RES bits, sign-extended), and the counter increments.
  - On the edge that accepts beat `INPUTS`, go to FIN.
  - Cycles with `in_valid` low leave the accumulator and counter unchanged; gaps of any length are legal.
- FIN:
  - `in_ready` = 0.
  - z = acc + (sext(bias) << BIAS_SHIFT).
  - y = z >>> OUT_SHIFT, which floors toward −∞.
  - If ACT = 1 and y < 0, y = 0.
  - Clamp y to [−2^(RES−1), 2^(RES−1)−1]. Set `out_sat` = 1 if the clamp changed the value, else 0.
  - Register `out_data` and `out_sat`, pulse `out_valid`, and return to IDLE.
- Widths:
  - The accumulator is 2·RES + clog2(INPUTS) + 1 bits and cannot overflow.
  - z carries 1 extra bit plus BIAS_SHIFT extra bits.
  - Every intermediate is signed. No truncation is allowed before the clamp.
- `in_ready` = 0 in IDLE and in FIN.

## Timing
- Reset values: `in_ready` 0, `out_valid` 0, `out_data` 0, `out_sat` 0, `busy` 0, accumulator 0, counter 0.
- Asserting `reset` mid-run takes effect immediately. The partial sum is discarded and no `out_valid` is produced.
- `start` sampled at edge t0 puts the block in ACC after t0, so `in_ready` is high in the cycle after t0.
- The last beat accepted at edge tL puts the block in FIN after tL.
- `out_valid` is high during the single cycle after edge tL+1. The state is IDLE during that cycle.
- With no gaps, `out_valid` appears INPUTS+2 cycles after the `start` cycle.
- A `start` asserted during the `out_valid` cycle is accepted. Back-to-back runs have 2 dead cycles on the input stream: FIN plus the restart.
- `busy` rises the cycle after the accepted `start` and falls in the `out_valid` cycle.
- `out_data` and `out_sat` change only at the FIN edge.

## Test plan
All scenarios use INPUTS=4 and RES=8.
- Basic: data {10,20,30,40}, weights all 1, bias 0, no gaps → `out_data`=100, `out_sat`=0, `out_valid` exactly 6 cycles after the `start` cycle, for one cycle.
- Positive saturation: data all 127, weights all 127 (sum 64516) → `out_data`=127, `out_sat`=1. With ACT=1 the result is the same.
- Negative saturation and ReLU: data all 127, weights all −128 (sum −65024) → ACT=0 gives −128 with `out_sat`=1; ACT=1 gives 0 with `out_sat`=0.
- Stream gaps and stray start: repeat Basic with `in_valid` low on alternate cycles, and pulse `start` during ACC → `out_data`=100, `out_valid` delayed by exactly the number of gap cycles, the stray `start` has no effect, and `in_ready` is 0 in IDLE and FIN.
- Reset mid-run: assert `reset` asynchronously after 2 beats → all outputs go to 0 immediately and no `out_valid` appears. A fresh Basic run afterwards returns 100.
- Shift, bias and back-to-back: OUT_SHIFT=6, BIAS_SHIFT=6, data all 16, weights all 16, bias −3 → z=1024−192=832, y=13, `out_sat`=0. A second `start` in the `out_valid` cycle with bias 0 returns 16, with no lost beats.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed neuron: one signed MAC per accepted beat, then bias, rescale,
// optional ReLU and saturation into a single registered result.
module neuron_mac_seq #(
  parameter int unsigned INPUTS     = 16,
  parameter int unsigned RES        = 8,
  parameter int unsigned BIAS_SHIFT = 0,
  parameter int unsigned OUT_SHIFT  = 0,
  parameter int unsigned ACT        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [RES-1:0] bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [RES-1:0] in_data,
  input  logic signed [RES-1:0] in_weight,
  output logic                  out_valid,
  output logic signed [RES-1:0] out_data,
  output logic                  out_sat,
  output logic                  busy
);

  localparam int unsigned AW = 2 * RES + $clog2(INPUTS) + 1;
  localparam int unsigned CW = $clog2(INPUTS + 1);
  localparam int unsigned ZW = AW + 1 + BIAS_SHIFT;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic signed [RES-1:0] MaxR = {1'b0, {(RES - 1){1'b1}}};
  localparam logic signed [RES-1:0] MinR = ~MaxR;
  localparam logic signed [ZW-1:0]  MaxZ = {{(ZW - RES){1'b0}}, MaxR};
  localparam logic signed [ZW-1:0]  MinZ = ~MaxZ;

  logic [1:0]            state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [RES-1:0] bias_q, bias_d;
  logic signed [RES-1:0] out_data_q, out_data_d;
  logic                  out_sat_q, out_sat_d;
  logic                  out_valid_q, out_valid_d;

  logic signed [2*RES-1:0] prod;
  logic signed [ZW-1:0]    acc_ext, bias_ext, z, y, y_act;
  logic signed [RES-1:0]   clamp;
  logic                    sat;

  // Full-width datapath; nothing is truncated until the clamp.
  always_comb begin
    prod     = in_data * in_weight;
    acc_ext  = {{(ZW - AW){acc_q[AW-1]}}, acc_q};
    bias_ext = {{(ZW - RES){bias_q[RES-1]}}, bias_q} << BIAS_SHIFT;
    z        = acc_ext + bias_ext;
    y        = z >>> OUT_SHIFT;
    y_act    = y;
    if (ACT == 1 && y[ZW-1]) begin
      y_act = '0;
    end
    if (y_act > MaxZ) begin
      clamp = MaxR;
      sat   = 1'b1;
    end else if (y_act < MinZ) begin
      clamp = MinR;
      sat   = 1'b1;
    end else begin
      clamp = y_act[RES-1:0];
      sat   = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bias_d      = bias_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bias_d  = bias;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = acc_q + {{(AW - 2 * RES){prod[2*RES-1]}}, prod};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(INPUTS - 1)) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        out_data_d  = clamp;
        out_sat_d   = sat;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
